mul_booth_pp_gen: RTL and testbench

//  Radix-4 Booth partial-product generator feeding the 33-input Wallace reducer of the EXU multiplier.

---
 rtl/mul_booth_pp_gen.sv | 162 ++++++++++++++++
 tb/tb_mul_booth_pp_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_booth_pp_gen.sv
// Radix-4 Booth partial-product generator: 33 products of WIDTH bits, one registered stage, valid/ready both sides.
// Optional one-entry skid buffer (registered ready) enabled by defining MUL_PP_SKID_EN.
module mul_booth_pp_gen #(
  parameter int XLEN  = 64,
  parameter int WIDTH = 2*(XLEN+2)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [XLEN-1:0]  i_src1,
  input  logic [XLEN-1:0]  i_src2,
  input  logic [2:0]       i_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_pp [(XLEN+2)/2],
  output logic [2:0]       o_op
);

  localparam int XW   = XLEN + 2;
  localparam int NDIG = XW / 2;

  logic             r_valid;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_pp [NDIG];

  logic             w_in_fire;
  logic             w_load;
  logic [XLEN-1:0]  w_a;
  logic [XLEN-1:0]  w_b;
  logic [2:0]       w_op_sel;

`ifdef MUL_PP_SKID_EN
  logic            r_skid_full;
  logic            r_ready;
  logic [XLEN-1:0] r_skid_a;
  logic [XLEN-1:0] r_skid_b;
  logic [2:0]      r_skid_op;

  assign o_ready   = r_ready;
  assign w_in_fire = i_valid && r_ready;
  // The skid entry is older than anything on the inputs, so it always loads first.
  assign w_a       = r_skid_full ? r_skid_a  : i_src1;
  assign w_b       = r_skid_full ? r_skid_b  : i_src2;
  assign w_op_sel  = r_skid_full ? r_skid_op : i_op;
  assign w_load    = !i_flush && (r_skid_full || w_in_fire) && (!r_valid || i_ready);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_skid_full <= 1'b0;
      r_ready     <= 1'b1;
      r_skid_a    <= '0;
      r_skid_b    <= '0;
      r_skid_op   <= '0;
    end else if (i_flush) begin
      r_skid_full <= 1'b0;
      r_ready     <= 1'b1;
    end else if (r_skid_full) begin
      if (!r_valid || i_ready) begin
        r_skid_full <= 1'b0;
        r_ready     <= 1'b1;
      end
    end else if (w_in_fire && r_valid && !i_ready) begin
      r_skid_full <= 1'b1;
      r_ready     <= 1'b0;
      r_skid_a    <= i_src1;
      r_skid_b    <= i_src2;
      r_skid_op   <= i_op;
    end
  end
`else
  assign o_ready   = !r_valid || i_ready;
  assign w_in_fire = i_valid && o_ready;
  assign w_a       = i_src1;
  assign w_b       = i_src2;
  assign w_op_sel  = i_op;
  assign w_load    = w_in_fire && !i_flush;
`endif

  logic [XLEN-1:0] w_a_w;
  logic [XLEN-1:0] w_b_w;
  logic [XW-1:0]   w_x;
  logic [XW-1:0]   w_y;

  assign w_a_w = {{(XLEN-32){w_a[31]}}, w_a[31:0]};
  assign w_b_w = {{(XLEN-32){w_b[31]}}, w_b[31:0]};

  always_comb begin
    w_x = {{2{w_a[XLEN-1]}}, w_a};
    w_y = {{2{w_b[XLEN-1]}}, w_b};
    case (w_op_sel)
      3'd2: w_y = {2'b00, w_b};
      3'd3: begin
        w_x = {2'b00, w_a};
        w_y = {2'b00, w_b};
      end
      3'd4: begin
        w_x = {{2{w_a_w[XLEN-1]}}, w_a_w};
        w_y = {{2{w_b_w[XLEN-1]}}, w_b_w};
      end
      default: ;
    endcase
  end

  logic [XW:0]      w_ybits;
  logic [NDIG-2:0]  w_neg;
  logic [WIDTH-1:0] w_pp [NDIG];

  assign w_ybits = {w_y, 1'b0};

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
    logic [2:0]       w_dig;
    logic             w_zero;
    logic             w_two;
    logic             w_neg_d;
    logic [WIDTH-1:0] w_mag;
    logic [WIDTH-1:0] w_term;
    logic [WIDTH-1:0] w_cin;

    assign w_dig   = w_ybits[2*gi +: 3];
    assign w_zero  = (w_dig == 3'b000) || (w_dig == 3'b111);
    assign w_two   = (w_dig == 3'b011) || (w_dig == 3'b100);
    assign w_neg_d = w_dig[2] && !w_zero;
    assign w_mag   = w_two ? {{(WIDTH-XW-1){w_x[XW-1]}}, w_x, 1'b0}
                           : {{(WIDTH-XW){w_x[XW-1]}}, w_x};
    assign w_term  = w_zero ? '0 : (w_neg_d ? ~w_mag : w_mag);

    // The +1 of the previous digit's negation lands in this product's zero low bits.
    if (gi == 0) begin : g_no_cin
      assign w_cin = '0;
    end else begin : g_cin
      assign w_cin = WIDTH'(w_neg[gi-1]) << (2*(gi-1));
    end
    if (gi < NDIG-1) begin : g_neg
      assign w_neg[gi] = w_neg_d;
    end

    assign w_pp[gi] = (w_term << (2*gi)) | w_cin;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_op    <= '0;
      for (int i = 0; i < NDIG; i++) r_pp[i] <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_op    <= w_op_sel;
      r_pp    <= w_pp;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_op    = r_op;
  assign o_pp    = r_pp;

endmodule

// File: tb/tb_mul_booth_pp_gen.sv
// Bench for mul_booth_pp_gen: directed literal cases plus randomized traffic against a queue-based product model.
module tb_mul_booth_pp_gen;

  logic         clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_flush = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [63:0]  i_src1 = '0;
  logic [63:0]  i_src2 = '0;
  logic [2:0]   i_op = '0;
  logic         o_valid;
  logic         i_ready = 1'b1;
  logic [131:0] o_pp [33];
  logic [2:0]   o_op;

  always #5 clk = ~clk;

  mul_booth_pp_gen #(.XLEN(64), .WIDTH(132)) dut (
    .i_clk   (clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_src1  (i_src1),
    .i_src2  (i_src2),
    .i_op    (i_op),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_pp    (o_pp),
    .o_op    (o_op)
  );

  typedef struct {
    logic [2:0]   op;
    logic [131:0] prod;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [131:0] got, input logic [131:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [131:0] pp_sum();
    logic [131:0] s = '0;
    for (int i = 0; i < 33; i++) s += o_pp[i];
    return s;
  endfunction

  function automatic logic [131:0] pp_or();
    logic [131:0] s = '0;
    for (int i = 0; i < 33; i++) s |= o_pp[i];
    return s;
  endfunction

  // Reference: extend both operands per op, then one plain multiply mod 2^132.
  function automatic logic [131:0] ref_prod(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [131:0] x;
    logic [131:0] y;
    x = {{68{a[63]}}, a};
    y = {{68{b[63]}}, b};
    case (op)
      3'd2: y = {68'b0, b};
      3'd3: begin x = {68'b0, a}; y = {68'b0, b}; end
      3'd4: begin x = {{100{a[31]}}, a[31:0]}; y = {{100{b[31]}}, b[31:0]}; end
      default: ;
    endcase
    return x * y;
  endfunction

  function automatic logic [63:0] pick64();
    case ($urandom_range(0, 5))
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Single compare process: every cycle the outputs are checked against the queue model.
  always @(negedge clk) begin
    if (!i_rst_n) begin
      q.delete();
    end else begin
      chk("valid", 132'(o_valid), 132'(q.size() != 0));
      if (o_valid && q.size() != 0) begin
        chk("pp_sum", pp_sum(), q[0].prod);
        chk("op", 132'(o_op), 132'(q[0].op));
      end
`ifndef MUL_PP_SKID_EN
      chk("ready", 132'(o_ready), 132'(!o_valid || i_ready));
`endif
      if (o_valid && i_ready && q.size() != 0) begin
        $display("xfer op=%0d sum=%h", o_op, pp_sum());
        void'(q.pop_front());
      end
      if (i_flush) q.delete();
      else if (i_valid && o_ready) q.push_back('{op: i_op, prod: ref_prod(i_op, i_src1, i_src2)});
    end
  end

  task automatic run1(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, output logic [131:0] s);
    int k;
    k = 0;
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_op    = op;
    i_src1  = a;
    i_src2  = b;
    @(posedge clk); #1;
    i_valid = 1'b0;
    while (!o_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("run1_timeout", 132'(o_valid), 132'(1));
    s = pp_sum();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [131:0] s;
    logic [131:0] s0;
    logic [2:0]   op0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 132'(o_valid), 132'(0));
    chk("rst_op", 132'(o_op), 132'(0));
    chk("rst_pp", pp_or(), 132'(0));
    i_rst_n = 1'b1;
    @(posedge clk); #1;

    run1(3'd0, 64'd3, 64'd5, s);
    chk("mul_3x5", 132'(s[63:0]), 132'(64'd15));
    run1(3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, s);
    chk("mulh_m1_hi", 132'(s[127:64]), 132'(0));
    chk("mulh_m1_lo", 132'(s[63:0]), 132'(1));
    run1(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, s);
    chk("mulhu_max_hi", 132'(s[127:64]), 132'(64'hFFFF_FFFF_FFFF_FFFE));
    run1(3'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000, s);
    chk("mulhsu_hi", 132'(s[127:64]), 132'(64'hFFFF_FFFF_FFFF_FFFF));
    run1(3'd4, 64'h1_0000_0007, 64'h1_FFFF_FFFF, s);
    chk("mulw_lo", 132'(s[31:0]), 132'(32'hFFFF_FFF9));

    // Stall for three cycles with a held product.
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_op    = 3'd1;
    i_src1  = 64'h1234_5678_9ABC_DEF0;
    i_src2  = 64'hFEDC_BA98_7654_3210;
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("stall_v0", 132'(o_valid), 132'(1));
    s0  = pp_sum();
    op0 = o_op;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_valid", 132'(o_valid), 132'(1));
      chk("stall_pp", pp_sum(), s0);
      chk("stall_op", 132'(o_op), 132'(op0));
`ifndef MUL_PP_SKID_EN
      chk("stall_ready", 132'(o_ready), 132'(0));
`endif
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_drain", 132'(o_valid), 132'(0));

    // Flush in the same cycle as an accept.
    i_flush = 1'b1;
    i_valid = 1'b1;
    i_op    = 3'd0;
    i_src1  = 64'd9;
    i_src2  = 64'd9;
    @(posedge clk); #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    chk("flush_accept", 132'(o_valid), 132'(0));
    run1(3'd0, 64'd7, 64'd6, s);
    chk("after_flush", 132'(s[63:0]), 132'(64'd42));

    // Flush of a held product.
    i_ready = 1'b0;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    chk("flush_held", 132'(o_valid), 132'(0));
    i_ready = 1'b1;

    // Asynchronous reset while a product is held.
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_op    = 3'd3;
    i_src1  = 64'hDEAD_BEEF_0000_0001;
    i_src2  = 64'h0000_0001_CAFE_F00D;
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("rst_mid_v", 132'(o_valid), 132'(1));
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 132'(o_valid), 132'(0));
    chk("rst_mid_op", 132'(o_op), 132'(0));
    chk("rst_mid_pp", pp_or(), 132'(0));
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    i_ready = 1'b1;

    repeat (3000) begin
      @(posedge clk); #1;
      i_valid = ($urandom_range(0, 9) < 7);
      i_ready = ($urandom_range(0, 9) < 7);
      i_flush = ($urandom_range(0, 49) == 0);
      i_op    = 3'($urandom_range(0, 7));
      i_src1  = pick64();
      i_src2  = pick64();
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    i_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
